// File: rtl/pattern_pwm_array_if.sv
// Configuration write port of pattern_pwm_array: a strobed write into per-channel
// shadow registers, acknowledged one cycle later.
interface pattern_pwm_array_if #(
  parameter int PAT_W  = 32,
  parameter int DUTY_W = 8,
  parameter int GAP_W  = 16,
  parameter int NUM_W  = 8
);
  // Handshake: the master holds cfg_wr high for exactly one clock with the
  // payload stable in that clock; there is no back-pressure. The slave raises
  // cfg_ack for one clock on the following cycle, and only for a valid cfg_ch.
  logic              cfg_wr;
  logic [3:0]        cfg_ch;
  logic [DUTY_W-1:0] cfg_duty;
  logic [GAP_W-1:0]  cfg_gap;
  logic [NUM_W-1:0]  cfg_num;
  logic [PAT_W-1:0]  cfg_pat;
  logic              cfg_ack;

  modport master (
    output cfg_wr, cfg_ch, cfg_duty, cfg_gap, cfg_num, cfg_pat,
    input  cfg_ack
  );

  modport slave (
    input  cfg_wr, cfg_ch, cfg_duty, cfg_gap, cfg_num, cfg_pat,
    output cfg_ack
  );
endinterface

// File: rtl/pattern_pwm_array.sv
// Multi-channel pattern PWM engine with glitch-free shadow-register commits.
// Optional PWM_SYNC_START_EN adds a sync_start input that gates every channel's start.
module pattern_pwm_array #(
  parameter int NUM_CH = 4,
  parameter int PAT_W  = 32,
  parameter int DUTY_W = 8,
  parameter int GAP_W  = 16,
  parameter int NUM_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_CH-1:0]     ch_en,
`ifdef PWM_SYNC_START_EN
  input  logic                  sync_start,
`endif
  pattern_pwm_array_if.slave    cfg,
  output logic [NUM_CH-1:0]     pwm_out,
  output logic [NUM_CH-1:0]     busy,
  output logic [NUM_CH-1:0]     valid,
  output logic [2*NUM_CH-1:0]   ch_state
);

  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PAT  = 2'd1,
    S_GAP  = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  logic [NUM_CH-1:0] ch_en_q;
  logic              ack_q;

  // Start is taken one edge after enable is first seen high, so PAT lands on edge n+1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_en_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      ch_en_q <= ch_en;
      ack_q   <= cfg.cfg_wr && ({1'b0, cfg.cfg_ch} < 5'(NUM_CH));
    end
  end

  assign cfg.cfg_ack = ack_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t            st_q, st_d;
    logic [DUTY_W-1:0] sh_duty_q, act_duty_q, act_duty_d;
    logic [GAP_W-1:0]  sh_gap_q, act_gap_q, act_gap_d;
    logic [NUM_W-1:0]  sh_num_q, act_num_q, act_num_d;
    logic [PAT_W-1:0]  sh_pat_q, shift_q, shift_d;
    logic [DUTY_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic [NUM_W-1:0]  rep_q, rep_d, rep_inc;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic              pwm_q, pwm_d;
    logic              valid_q, valid_d;
    logic              sel, start_ok, bit_last, pat_last, commit;

    assign sel = cfg.cfg_wr && (cfg.cfg_ch == 4'(i));

`ifdef PWM_SYNC_START_EN
    assign start_ok = ch_en[i] && ch_en_q[i] && sync_start;
`else
    assign start_ok = ch_en[i] && ch_en_q[i];
`endif

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sh_duty_q <= '0;
        sh_gap_q  <= '0;
        sh_num_q  <= '0;
        sh_pat_q  <= '0;
      end else if (sel) begin
        sh_duty_q <= cfg.cfg_duty;
        sh_gap_q  <= cfg.cfg_gap;
        sh_num_q  <= cfg.cfg_num;
        sh_pat_q  <= cfg.cfg_pat;
      end
    end

    // Duty of 0 or 1 both give single-clock bits.
    assign bit_last = (act_duty_q <= DUTY_W'(1)) || (bit_cnt_q == act_duty_q - DUTY_W'(1));
    assign pat_last = (bit_idx_q == IDX_W'(PAT_W - 1));
    // Saturating repeat count: infinite runs never wrap back onto a finite match.
    assign rep_inc  = (&rep_q) ? rep_q : rep_q + NUM_W'(1);

    always_comb begin
      st_d       = st_q;
      act_duty_d = act_duty_q;
      act_gap_d  = act_gap_q;
      act_num_d  = act_num_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      bit_idx_d  = bit_idx_q;
      rep_d      = rep_q;
      gap_cnt_d  = gap_cnt_q;
      valid_d    = 1'b0;
      commit     = 1'b0;
      case (st_q)
        S_IDLE: begin
          if (start_ok) begin
            commit = 1'b1;
            rep_d  = '0;
            st_d   = S_PAT;
          end
        end
        S_PAT: begin
          if (!ch_en[i]) begin
            st_d = S_IDLE;
          end else if (!bit_last) begin
            bit_cnt_d = bit_cnt_q + DUTY_W'(1);
          end else begin
            bit_cnt_d = '0;
            shift_d   = shift_q << 1;
            if (!pat_last) begin
              bit_idx_d = bit_idx_q + IDX_W'(1);
            end else begin
              bit_idx_d = '0;
              rep_d     = rep_inc;
              if ((act_num_q != '0) && (rep_inc == act_num_q)) begin
                st_d    = S_HOLD;
                valid_d = 1'b1;
              end else if (act_gap_q != '0) begin
                st_d      = S_GAP;
                gap_cnt_d = '0;
              end else begin
                commit = 1'b1;
              end
            end
          end
        end
        S_GAP: begin
          if (!ch_en[i]) begin
            st_d = S_IDLE;
          end else if (gap_cnt_q == act_gap_q - GAP_W'(1)) begin
            commit = 1'b1;
            st_d   = S_PAT;
          end else begin
            gap_cnt_d = gap_cnt_q + GAP_W'(1);
          end
        end
        S_HOLD: begin
          if (!ch_en[i]) st_d = S_IDLE;
        end
        default: st_d = S_IDLE;
      endcase
      // A commit samples the shadow's pre-edge value, so a same-cycle write waits a boundary.
      if (commit) begin
        act_duty_d = sh_duty_q;
        act_gap_d  = sh_gap_q;
        act_num_d  = sh_num_q;
        shift_d    = sh_pat_q;
        bit_cnt_d  = '0;
        bit_idx_d  = '0;
      end
      pwm_d = (st_d == S_PAT) && shift_d[PAT_W-1];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        st_q       <= S_IDLE;
        act_duty_q <= '0;
        act_gap_q  <= '0;
        act_num_q  <= '0;
        shift_q    <= '0;
        bit_cnt_q  <= '0;
        bit_idx_q  <= '0;
        rep_q      <= '0;
        gap_cnt_q  <= '0;
        pwm_q      <= 1'b0;
        valid_q    <= 1'b0;
      end else begin
        st_q       <= st_d;
        act_duty_q <= act_duty_d;
        act_gap_q  <= act_gap_d;
        act_num_q  <= act_num_d;
        shift_q    <= shift_d;
        bit_cnt_q  <= bit_cnt_d;
        bit_idx_q  <= bit_idx_d;
        rep_q      <= rep_d;
        gap_cnt_q  <= gap_cnt_d;
        pwm_q      <= pwm_d;
        valid_q    <= valid_d;
      end
    end

    assign pwm_out[i]          = pwm_q;
    assign valid[i]            = valid_q;
    assign busy[i]             = (st_q == S_PAT) || (st_q == S_GAP);
    assign ch_state[2*i +: 2]  = st_q;
  end

endmodule

// File: tb/tb_pattern_pwm_array.sv
// Self-checking bench for pattern_pwm_array: directed scenarios plus randomized
// multi-channel runs compared against a per-cycle waveform model built from arithmetic.
module tb_pattern_pwm_array;

  localparam int NUM_CH = 4;
  localparam int PAT_W  = 8;
  localparam int DUTY_W = 8;
  localparam int GAP_W  = 16;
  localparam int NUM_W  = 8;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NUM_CH-1:0]   ch_en = '0;
  logic [NUM_CH-1:0]   pwm_out, busy, valid;
  logic [2*NUM_CH-1:0] ch_state;
`ifdef PWM_SYNC_START_EN
  logic                sync_start = 1'b0;
`endif

  pattern_pwm_array_if #(.PAT_W(PAT_W), .DUTY_W(DUTY_W), .GAP_W(GAP_W), .NUM_W(NUM_W)) cfg_bus ();

  pattern_pwm_array #(
    .NUM_CH(NUM_CH), .PAT_W(PAT_W), .DUTY_W(DUTY_W), .GAP_W(GAP_W), .NUM_W(NUM_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ch_en     (ch_en),
`ifdef PWM_SYNC_START_EN
    .sync_start(sync_start),
`endif
    .cfg       (cfg_bus),
    .pwm_out   (pwm_out),
    .busy      (busy),
    .valid     (valid),
    .ch_state  (ch_state)
  );

  // ---------------- clock / reset ----------------
  always #10 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int vectors     = 0;
  int miscompares = 0;
  logic [NUM_CH-1:0] exp_pwm_q[$];
  logic [NUM_CH-1:0] exp_busy_q[$];
  logic [NUM_CH-1:0] exp_val_q[$];

  int               tr_d[NUM_CH];
  int               tr_g[NUM_CH];
  int               tr_n[NUM_CH];
  logic [PAT_W-1:0] tr_p[NUM_CH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Level of the output t clocks after PAT entry, for a run that has not yet ended.
  function automatic logic exp_bit(input int t, input int de, input int g, input logic [PAT_W-1:0] p);
    int per;
    int off;
    per = PAT_W * de + g;
    off = t % per;
    if (off < PAT_W * de) return p[PAT_W-1 - off/de];
    return 1'b0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cfg_write(input int ch, input int duty, input int gap, input int num,
                           input logic [PAT_W-1:0] pat);
    cfg_bus.cfg_wr   = 1'b1;
    cfg_bus.cfg_ch   = ch[3:0];
    cfg_bus.cfg_duty = duty[DUTY_W-1:0];
    cfg_bus.cfg_gap  = gap[GAP_W-1:0];
    cfg_bus.cfg_num  = num[NUM_W-1:0];
    cfg_bus.cfg_pat  = pat;
    @(negedge clk);
    cfg_bus.cfg_wr   = 1'b0;
    check("cfg_ack", 32'(cfg_bus.cfg_ack), 32'(ch < NUM_CH));
  endtask

  // Program every channel from tr_*, enable those in mask, and follow the run to HOLD.
  task automatic run_trial(input logic [NUM_CH-1:0] mask);
    int de[NUM_CH];
    int len[NUM_CH];
    int tmax;
    logic [NUM_CH-1:0] e_pwm, e_busy, e_val;
    for (int c = 0; c < NUM_CH; c++) cfg_write(c, tr_d[c], tr_g[c], tr_n[c], tr_p[c]);
    cfg_write($urandom_range(NUM_CH, 15), $urandom_range(0, 3), $urandom_range(0, 4),
              $urandom_range(1, 3), PAT_W'($urandom));
    tmax = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      de[c]  = (tr_d[c] == 0) ? 1 : tr_d[c];
      len[c] = tr_n[c] * PAT_W * de[c] + (tr_n[c] - 1) * tr_g[c];
      if (mask[c] && len[c] > tmax) tmax = len[c];
    end
    exp_pwm_q.delete();
    exp_busy_q.delete();
    exp_val_q.delete();
    for (int t = 0; t < tmax + 3; t++) begin
      e_pwm = '0; e_busy = '0; e_val = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        if (mask[c]) begin
          e_pwm[c]  = (t < len[c]) ? exp_bit(t, de[c], tr_g[c], tr_p[c]) : 1'b0;
          e_busy[c] = (t < len[c]);
          e_val[c]  = (t == len[c]);
        end
      end
      exp_pwm_q.push_back(e_pwm);
      exp_busy_q.push_back(e_busy);
      exp_val_q.push_back(e_val);
    end
    ch_en = mask;
    @(negedge clk);
    check("busy_before_start", 32'(busy), 32'(0));
    while (exp_pwm_q.size() > 0) begin
      @(negedge clk);
      check("run_pwm", 32'(pwm_out), 32'(exp_pwm_q.pop_front()));
      check("run_busy", 32'(busy), 32'(exp_busy_q.pop_front()));
      check("run_valid", 32'(valid), 32'(exp_val_q.pop_front()));
    end
    ch_en = '0;
    @(negedge clk);
    check("release_state", 32'(ch_state), 32'(0));
    check("release_pwm", 32'(pwm_out), 32'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [PAT_W-1:0] pat_now;
    cfg_bus.cfg_wr   = 1'b0;
    cfg_bus.cfg_ch   = '0;
    cfg_bus.cfg_duty = '0;
    cfg_bus.cfg_gap  = '0;
    cfg_bus.cfg_num  = '0;
    cfg_bus.cfg_pat  = '0;

    // Reset state
    #5;
    check("reset_pwm", 32'(pwm_out), 32'(0));
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_valid", 32'(valid), 32'(0));
    check("reset_ack", 32'(cfg_bus.cfg_ack), 32'(0));
    check("reset_state", 32'(ch_state), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed run on ch0: duty 2, gap 4, two repeats of 0xA5; then again with
    // enable re-toggled to show a fresh repeat count.
    for (int c = 0; c < NUM_CH; c++) begin
      tr_d[c] = 1; tr_g[c] = 1; tr_n[c] = 1; tr_p[c] = '0;
    end
    tr_d[0] = 2; tr_g[0] = 4; tr_n[0] = 2; tr_p[0] = 8'hA5;
    run_trial(4'b0001);
    run_trial(4'b0001);

    // Infinite 1-in-8 train, no gap, duty 0
    cfg_write(0, 0, 0, 0, 8'h80);
    ch_en = 4'b0001;
    @(negedge clk);
    for (int t = 0; t < 1000; t++) begin
      @(negedge clk);
      check("inf_pwm", 32'(pwm_out), 32'((t % 8) == 0));
      check("inf_valid_busy", 32'({valid, busy}), 32'({4'b0000, 4'b0001}));
    end
    ch_en = '0;
    @(negedge clk);

    // Mid-pattern rewrite of ch1: 0x0F finishes, 0xFF starts after the gap
    cfg_write(1, 1, 2, 0, 8'h0F);
    ch_en = 4'b0010;
    @(negedge clk);
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      pat_now = (t < 10) ? 8'h0F : 8'hFF;
      check("rewrite_pwm", 32'(pwm_out), 32'({2'b00, exp_bit(t, 1, 2, pat_now), 1'b0}));
      if (t == 3) begin
        cfg_bus.cfg_wr  = 1'b1;
        cfg_bus.cfg_ch  = 4'd1;
        cfg_bus.cfg_pat = 8'hFF;
      end
      if (t == 4) begin
        cfg_bus.cfg_wr = 1'b0;
        check("rewrite_ack", 32'(cfg_bus.cfg_ack), 32'(1));
      end
      if (t == 5) check("rewrite_ack_once", 32'(cfg_bus.cfg_ack), 32'(0));
    end
    ch_en = '0;
    @(negedge clk);

    // Abort ch2 during its gap
    pat_now = PAT_W'($urandom) | 8'h01;
    cfg_write(2, 1, 6, 3, pat_now);
    ch_en = 4'b0100;
    @(negedge clk);
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      check("abort_pre_pwm", 32'(pwm_out), 32'({1'b0, exp_bit(t, 1, 6, pat_now), 2'b00}));
    end
    ch_en = '0;
    @(negedge clk);
    check("abort_pwm", 32'(pwm_out), 32'(0));
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_state", 32'(ch_state), 32'(0));
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      check("abort_no_valid", 32'(valid), 32'(0));
    end

    // Asynchronous reset in the middle of a pattern
    cfg_write(0, 1, 0, 0, 8'hFF);
    ch_en = 4'b0001;
    @(negedge clk);
    for (int t = 0; t < 3; t++) @(negedge clk);
    check("pre_reset_pwm", 32'(pwm_out), 32'(1));
    #3 rst = 1'b1;
    #1;
    check("async_reset_pwm", 32'(pwm_out), 32'(0));
    check("async_reset_busy", 32'(busy), 32'(0));
    check("async_reset_state", 32'(ch_state), 32'(0));
    check("async_reset_valid", 32'(valid), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    // Cleared shadows start an all-zero infinite run
    @(negedge clk);
    @(negedge clk);
    check("zero_shadow_busy", 32'(busy), 32'(1));
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      check("zero_shadow_pwm", 32'({valid, pwm_out}), 32'(0));
    end
    ch_en = '0;
    @(negedge clk);

`ifdef PWM_SYNC_START_EN
    // Two channels armed ten cycles apart start together on sync_start
    cfg_write(0, 1, 0, 1, 8'hC3);
    cfg_write(1, 1, 0, 1, 8'hC3);
    ch_en = 4'b0001;
    for (int t = 0; t < 10; t++) @(negedge clk);
    ch_en = 4'b0011;
    for (int t = 0; t < 5; t++) @(negedge clk);
    check("sync_armed_busy", 32'(busy), 32'(0));
    sync_start = 1'b1;
    @(negedge clk);
    sync_start = 1'b0;
    for (int t = 0; t < 8; t++) begin
      check("sync_pwm", 32'(pwm_out), 32'({2'b00, {2{exp_bit(t, 1, 0, 8'hC3)}}}));
      check("sync_busy", 32'(busy), 32'(4'b0011));
      @(negedge clk);
    end
    ch_en = '0;
    @(negedge clk);
`endif

    // Randomized concurrent runs
    for (int k = 0; k < 12; k++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        tr_d[c] = $urandom_range(0, 3);
        tr_g[c] = $urandom_range(0, 4);
        tr_n[c] = $urandom_range(1, 3);
        tr_p[c] = PAT_W'($urandom);
      end
      run_trial(NUM_CH'($urandom_range(1, 15)));
    end

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
